// File: rtl/gpio_cfg_pkg.sv
// Shared constants, per-pad config field layout and FSM state type for gpio_cfg_chain.
package gpio_cfg_pkg;

    localparam int unsigned CFG_BITS     = 6;
    localparam int unsigned CFG_MGMT_ENA = 0;
    localparam int unsigned CFG_OUTENB   = 1;
    localparam int unsigned CFG_INP_DIS  = 2;
    localparam int unsigned CFG_DM_LO    = 3;
    localparam int unsigned CFG_DM_W     = 3;

    localparam logic [CFG_DM_W-1:0] DM_INPUT  = 3'b001;
    localparam logic [CFG_DM_W-1:0] DM_STRONG = 3'b110;

    // Power-up pad state: management-owned, output disabled, input-only drive mode.
    localparam logic [CFG_BITS-1:0] CFG_DEFAULT = {DM_INPUT, 1'b0, 1'b1, 1'b1};

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/gpio_cfg_slot.sv
// One pad: committed configuration register plus management/user output and input steering.
module gpio_cfg_slot
    import gpio_cfg_pkg::*;
(
    input  logic                clock,
    input  logic                resetn,
    input  logic                commit,
    input  logic [CFG_BITS-1:0] cfg_in,
    input  logic                mgmt_out,
    input  logic                user_out,
    input  logic                user_oeb,
    input  logic                pad_in,
    output logic                pad_out,
    output logic                pad_oeb,
    output logic                pad_inp_dis,
    output logic [CFG_DM_W-1:0] pad_dm,
    output logic                user_in,
    output logic                mgmt_in
);

    logic [CFG_BITS-1:0] cfg_q;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            cfg_q <= CFG_DEFAULT;
        end else if (commit) begin
            cfg_q <= cfg_in;
        end
    end

    // Zero-latency steering; only the selection itself is registered.
    always_comb begin
        pad_out     = user_out;
        pad_oeb     = user_oeb;
        user_in     = pad_in;
        mgmt_in     = pad_in;
        pad_inp_dis = cfg_q[CFG_INP_DIS];
        pad_dm      = cfg_q[CFG_DM_LO +: CFG_DM_W];
        if (cfg_q[CFG_MGMT_ENA]) begin
            pad_out = mgmt_out;
            pad_oeb = cfg_q[CFG_OUTENB];
            user_in = 1'b0;
        end
    end

endmodule

// File: rtl/gpio_cfg_chain.sv
// Serial pad-configuration loader: shadow shift register, length-checked commit, per-pad steering.
module gpio_cfg_chain #(
    parameter int unsigned NPADS    = 38,
    parameter int unsigned CFG_BITS = gpio_cfg_pkg::CFG_BITS
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 cfg_data,
    input  logic                 cfg_valid,
    input  logic                 cfg_load,
    output logic                 cfg_busy,
    output logic                 cfg_done,
    output logic                 cfg_err,
    input  logic [NPADS-1:0]     mgmt_out,
    output logic [NPADS-1:0]     mgmt_in,
    input  logic [NPADS-1:0]     user_out,
    input  logic [NPADS-1:0]     user_oeb,
    output logic [NPADS-1:0]     user_in,
    input  logic [NPADS-1:0]     pad_in,
    output logic [NPADS-1:0]     pad_out,
    output logic [NPADS-1:0]     pad_oeb,
    output logic [NPADS-1:0]     pad_inp_dis,
    output logic [3*NPADS-1:0]   pad_dm
);

    localparam int unsigned SW = NPADS * CFG_BITS;
    localparam int unsigned CW = $clog2(SW + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(SW);
    localparam logic [CW-1:0] CNT_OVF  = CW'(SW + 1);

    gpio_cfg_pkg::state_t state_q, state_d;
    logic [SW-1:0] shadow_q, shadow_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          commit;
    logic          done_d, err_d;
    logic          done_q, err_q;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= gpio_cfg_pkg::IDLE;
            shadow_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // A bit arriving together with the load is shifted in and counted before the length check.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        cnt_inc  = cnt_q;
        commit   = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;

        if (cfg_valid) begin
            shadow_d = {shadow_q[SW-2:0], cfg_data};
            if (cnt_q != CNT_OVF) begin
                cnt_inc = cnt_q + CW'(1);
            end
        end

        case (state_q)
            gpio_cfg_pkg::IDLE: begin
                if (cfg_load) begin
                    err_d = 1'b1;
                    cnt_d = '0;
                end else if (cfg_valid) begin
                    state_d = gpio_cfg_pkg::SHIFT;
                    cnt_d   = cnt_inc;
                end
            end
            gpio_cfg_pkg::SHIFT: begin
                if (cfg_load) begin
                    state_d = gpio_cfg_pkg::IDLE;
                    cnt_d   = '0;
                    if (cnt_inc == CNT_FULL) begin
                        commit = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = gpio_cfg_pkg::IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign cfg_busy = (state_q == gpio_cfg_pkg::SHIFT);
    assign cfg_done = done_q;
    assign cfg_err  = err_q;

    for (genvar i = 0; i < int'(NPADS); i++) begin : g_slot
        gpio_cfg_slot u_slot (
            .clock       (clock),
            .resetn      (resetn),
            .commit      (commit),
            .cfg_in      (shadow_d[i*CFG_BITS +: CFG_BITS]),
            .mgmt_out    (mgmt_out[i]),
            .user_out    (user_out[i]),
            .user_oeb    (user_oeb[i]),
            .pad_in      (pad_in[i]),
            .pad_out     (pad_out[i]),
            .pad_oeb     (pad_oeb[i]),
            .pad_inp_dis (pad_inp_dis[i]),
            .pad_dm      (pad_dm[3*i +: 3]),
            .user_in     (user_in[i]),
            .mgmt_in     (mgmt_in[i])
        );
    end

endmodule

// File: tb/tb_gpio_cfg_chain.sv
// Directed bench for gpio_cfg_chain: stream lengths, commit/reject pulses and pad steering.
module tb_gpio_cfg_chain;

    localparam int unsigned NPADS = 38;
    localparam int unsigned CB    = 6;
    localparam int unsigned SW    = NPADS * CB;

    logic                 clock = 1'b0;
    logic                 resetn;
    logic                 cfg_data, cfg_valid, cfg_load;
    logic                 cfg_busy, cfg_done, cfg_err;
    logic [NPADS-1:0]     mgmt_out, mgmt_in, user_out, user_oeb, user_in, pad_in;
    logic [NPADS-1:0]     pad_out, pad_oeb, pad_inp_dis;
    logic [3*NPADS-1:0]   pad_dm;

    logic [SW-1:0] vec_def, vec_p5, vec_p0, exp_cfg;
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    gpio_cfg_chain #(.NPADS(NPADS), .CFG_BITS(CB)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .cfg_data    (cfg_data),
        .cfg_valid   (cfg_valid),
        .cfg_load    (cfg_load),
        .cfg_busy    (cfg_busy),
        .cfg_done    (cfg_done),
        .cfg_err     (cfg_err),
        .mgmt_out    (mgmt_out),
        .mgmt_in     (mgmt_in),
        .user_out    (user_out),
        .user_oeb    (user_oeb),
        .user_in     (user_in),
        .pad_in      (pad_in),
        .pad_out     (pad_out),
        .pad_oeb     (pad_oeb),
        .pad_inp_dis (pad_inp_dis),
        .pad_dm      (pad_dm)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else n_pass++;
    endtask

    // Expected pad-side values derived from the bench's own view of the committed config.
    task automatic check_pads(input string tag);
        logic [NPADS-1:0]   e_out, e_oeb, e_inp, e_uin;
        logic [3*NPADS-1:0] e_dm;
        logic [CB-1:0]      c;
        for (int i = 0; i < int'(NPADS); i++) begin
            c = exp_cfg[i*CB +: CB];
            e_inp[i]      = c[2];
            e_dm[3*i +: 3] = c[5:3];
            e_out[i]      = c[0] ? mgmt_out[i] : user_out[i];
            e_oeb[i]      = c[0] ? c[1]        : user_oeb[i];
            e_uin[i]      = c[0] ? 1'b0        : pad_in[i];
        end
        check({tag, ".out"}, 128'(pad_out), 128'(e_out));
        check({tag, ".oeb"}, 128'(pad_oeb), 128'(e_oeb));
        check({tag, ".inp_dis"}, 128'(pad_inp_dis), 128'(e_inp));
        check({tag, ".dm"}, 128'(pad_dm), 128'(e_dm));
        check({tag, ".user_in"}, 128'(user_in), 128'(e_uin));
        check({tag, ".mgmt_in"}, 128'(mgmt_in), 128'(pad_in));
    endtask

    // Sends n bits MSB-first from v; bits beyond SW are extra leading ones.
    task automatic shift_bits(input logic [SW-1:0] v, input int n, input bit load_last);
        int idx;
        for (int k = 0; k < n; k++) begin
            idx = n - 1 - k;
            @(negedge clock);
            cfg_valid = 1'b1;
            cfg_data  = (idx < int'(SW)) ? v[idx] : 1'b1;
            cfg_load  = load_last && (k == n - 1);
        end
        if (load_last) begin
            @(negedge clock);
            cfg_valid = 1'b0;
            cfg_load  = 1'b0;
        end
    endtask

    task automatic do_load();
        @(negedge clock);
        cfg_valid = 1'b0;
        cfg_load  = 1'b1;
        @(negedge clock);
        cfg_load  = 1'b0;
    endtask

    task automatic check_status(input string tag, input logic busy, input logic done, input logic err);
        check({tag, ".busy"}, 128'(cfg_busy), 128'(busy));
        check({tag, ".done"}, 128'(cfg_done), 128'(done));
        check({tag, ".err"},  128'(cfg_err),  128'(err));
    endtask

    initial begin
        vec_def = {NPADS{6'b001_0_1_1}};
        vec_p5  = vec_def;
        vec_p5[5*CB +: CB] = 6'b110_0_0_0;
        vec_p0  = vec_def;
        vec_p0[0 +: CB] = 6'b001_0_1_0;

        resetn    = 1'b0;
        cfg_data  = 1'b0;
        cfg_valid = 1'b0;
        cfg_load  = 1'b0;
        mgmt_out  = 38'h15_A5A5_A5A5;
        user_out  = 38'h2C_3C3C_0F0F;
        user_oeb  = 38'h0F_F00F_1234;
        pad_in    = 38'h33_9876_CAFE;
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;

        // Reset defaults and zero-latency mux
        exp_cfg = vec_def;
        check_status("rst", 1'b0, 1'b0, 1'b0);
        check_pads("rst");
        check("rst.dm_lit", 128'(pad_dm), 128'({NPADS{3'b001}}));
        mgmt_out = 38'h0A_5A5A_5A5A;
        #1;
        check("mux_zero_lat", 128'(pad_out), 128'(38'h0A_5A5A_5A5A));

        // Load with nothing received
        do_load();
        check_status("idle_load", 1'b0, 1'b0, 1'b1);
        @(negedge clock);
        check("idle_load.err_clr", 128'(cfg_err), 128'(1'b0));

        // Pad 5 to user control, strong drive
        shift_bits(vec_p5, SW, 1'b0);
        check("p5.busy_mid", 128'(cfg_busy), 128'(1'b1));
        do_load();
        check_status("p5", 1'b0, 1'b1, 1'b0);
        exp_cfg = vec_p5;
        check_pads("p5");
        check("p5.dm5", 128'(pad_dm[17:15]), 128'(3'b110));
        check("p5.oeb5", 128'(pad_oeb[5]), 128'(user_oeb[5]));
        check("p5.uin5", 128'(user_in[5]), 128'(pad_in[5]));
        @(negedge clock);
        check("p5.done_clr", 128'(cfg_done), 128'(1'b0));

        // Short stream rejected
        shift_bits(vec_def, SW - 1, 1'b0);
        do_load();
        check_status("short", 1'b0, 1'b0, 1'b1);
        check_pads("short");
        @(negedge clock);
        check("short.err_clr", 128'(cfg_err), 128'(1'b0));

        // Overlong stream rejected, then a good stream commits
        shift_bits(vec_def, SW + 1, 1'b0);
        do_load();
        check_status("long", 1'b0, 1'b0, 1'b1);
        check_pads("long");
        shift_bits(vec_def, SW, 1'b0);
        do_load();
        check_status("long_fix", 1'b0, 1'b1, 1'b0);
        exp_cfg = vec_def;
        check_pads("long_fix");

        // Last bit and load in the same cycle
        shift_bits(vec_p0, SW, 1'b1);
        check_status("same", 1'b0, 1'b1, 1'b0);
        exp_cfg = vec_p0;
        check_pads("same");
        check("same.oeb0", 128'(pad_oeb[0]), 128'(user_oeb[0]));
        check("same.out0", 128'(pad_out[0]), 128'(user_out[0]));

        // Reset mid-stream
        shift_bits(vec_p5, 100, 1'b0);
        @(negedge clock);
        resetn    = 1'b0;
        cfg_valid = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        exp_cfg = vec_def;
        check_status("rst2", 1'b0, 1'b0, 1'b0);
        check_pads("rst2");
        shift_bits(vec_p5, SW, 1'b0);
        do_load();
        check_status("rst2_load", 1'b0, 1'b1, 1'b0);
        exp_cfg = vec_p5;
        check_pads("rst2_load");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
